// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-file signal bundle for mem_access_arbiter.
// slave: the arbiter's view; master: the environment (requesters plus memory file).
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    // Port 0: CPU load/store stage
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;

    // Port 1: debug/loader
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;

    // Memory file side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ldr_str_en;
    logic              mem_load_en;
    logic              mem_store_en;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              owner;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, done0, rdata0,
        output gnt1, done1, rdata1,
        output mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
        output busy, owner
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, done0, rdata0,
        input  gnt1, done1, rdata1,
        input  mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
        input  busy, owner
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter in front of the 16 x 32 data memory file.
// Each transaction: IDLE (accept) -> ACCESS (memory strobe) -> RESP (done pulse).
// Every output is a register; nothing combinational reaches the ports from req.
module mem_access_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_access_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              favour;     // port that wins a tie; 0 after reset
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Pick the winning requester and mux its request fields
    always_comb begin
        sel_port = 1'b0;
        if (bus.req0 && bus.req1) begin
            sel_port = favour;
        end else if (bus.req1) begin
            sel_port = 1'b1;
        end
        sel_we    = sel_port ? bus.we1    : bus.we0;
        sel_addr  = sel_port ? bus.addr1  : bus.addr0;
        sel_wdata = sel_port ? bus.wdata1 : bus.wdata0;
    end

    // Transaction FSM with registered handshake, memory strobes and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            favour             <= 1'b0;
            bus.gnt0           <= 1'b0;
            bus.gnt1           <= 1'b0;
            bus.done0          <= 1'b0;
            bus.done1          <= 1'b0;
            bus.rdata0         <= '0;
            bus.rdata1         <= '0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.mem_ldr_str_en <= 1'b0;
            bus.mem_load_en    <= 1'b0;
            bus.mem_store_en   <= 1'b0;
            bus.busy           <= 1'b0;
            bus.owner          <= 1'b0;
        end else begin
            bus.gnt0           <= 1'b0;
            bus.gnt1           <= 1'b0;
            bus.done0          <= 1'b0;
            bus.done1          <= 1'b0;
            bus.mem_ldr_str_en <= 1'b0;
            bus.mem_load_en    <= 1'b0;
            bus.mem_store_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        // The strobe registers themselves hold the latched request
                        state              <= ACCESS;
                        bus.busy           <= 1'b1;
                        bus.owner          <= sel_port;
                        bus.gnt0           <= ~sel_port;
                        bus.gnt1           <= sel_port;
                        bus.mem_addr       <= sel_addr;
                        bus.mem_wdata      <= sel_wdata;
                        bus.mem_ldr_str_en <= 1'b1;
                        bus.mem_store_en   <= sel_we;
                        bus.mem_load_en    <= ~sel_we;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (bus.mem_load_en) begin
                        if (bus.owner) begin
                            bus.rdata1 <= bus.mem_rdata;
                        end else begin
                            bus.rdata0 <= bus.mem_rdata;
                        end
                    end
                    bus.done0 <= ~bus.owner;
                    bus.done1 <= bus.owner;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    favour   <= ~bus.owner;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized
// single/contending transactions against a transaction-level memory model.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    mem_access_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Requester drive
    logic [1:0]  req = '0;
    logic [1:0]  we  = '0;
    logic [3:0]  addr [2];
    logic [31:0] wd   [2];

    assign bus.req0   = req[0];
    assign bus.we0    = we[0];
    assign bus.addr0  = addr[0];
    assign bus.wdata0 = wd[0];
    assign bus.req1   = req[1];
    assign bus.we1    = we[1];
    assign bus.addr1  = addr[1];
    assign bus.wdata1 = wd[1];

    // Memory file stand-in: asynchronous read, write on the clock edge
    logic [31:0] mem [16];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_store_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] rd [2];
    assign gnt   = {bus.gnt1, bus.gnt0};
    assign done  = {bus.done1, bus.done0};
    assign rd[0] = bus.rdata0;
    assign rd[1] = bus.rdata1;

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd  [2];
    int          fav;
    int          checks   = 0;
    int          failures = 0;
    int          load_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Mutual exclusion of grants and load-strobe accounting
    always @(negedge clk) begin
        if (bus.mem_load_en === 1'b1) load_cycles++;
        if (!rst) check("gnt_exclusive", 32'(gnt === 2'b11), 32'd0);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {23'd0, gnt, done, bus.mem_ldr_str_en, bus.mem_load_en,
                               bus.mem_store_en, bus.busy, bus.owner}, 32'd0);
        check({tag, "_rdata0"}, rd[0], 32'd0);
        check({tag, "_rdata1"}, rd[1], 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fav = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // One transaction of port p, whose request is already presented and will win.
    // drop: request lines to release once the grant is seen.
    task automatic serve(input int p, input logic [1:0] drop);
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        w = we[p];
        a = addr[p];
        d = wd[p];
        @(posedge clk); #1;
        check("gnt", 32'(gnt), 32'(1) << p);
        check("busy_access", 32'(bus.busy), 32'd1);
        check("owner", 32'(bus.owner), 32'(p));
        check("ldr_str_en", 32'(bus.mem_ldr_str_en), 32'd1);
        check("store_en", 32'(bus.mem_store_en), 32'(w));
        check("load_en", 32'(bus.mem_load_en), 32'(!w));
        check("mem_addr", 32'(bus.mem_addr), 32'(a));
        if (w) check("mem_wdata", bus.mem_wdata, d);
        for (int i = 0; i < 2; i++) begin
            if (drop[i]) req[i] = 1'b0;
        end
        if (drop[p]) begin
            addr[p] = 4'($urandom);
            wd[p]   = $urandom;
        end
        @(posedge clk); #1;
        if (w) ref_mem[a] = d;
        else   exp_rd[p] = ref_mem[a];
        check("done", 32'(done), 32'(1) << p);
        check("gnt_resp", 32'(gnt), 32'd0);
        check("enables_resp", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
        check("rdata0", rd[0], exp_rd[0]);
        check("rdata1", rd[1], exp_rd[1]);
        check("mem_addr_hold", 32'(bus.mem_addr), 32'(a));
        @(posedge clk); #1;
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("done_idle", 32'(done), 32'd0);
        fav = 1 - p;
    endtask

    task automatic present(input int p, input logic w, input logic [3:0] a, input logic [31:0] d);
        req[p]  = 1'b1;
        we[p]   = w;
        addr[p] = a;
        wd[p]   = d;
    endtask

    initial begin
        int lc;
        int r;
        int first;
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check_all_zero("reset_idle");
            @(posedge clk); #1;
        end

        // Port 0 store then load of the same word
        present(0, 1'b1, 4'd5, 32'hDEADBEEF);
        serve(0, 2'b01);
        present(0, 1'b0, 4'd5, 32'h0);
        serve(0, 2'b01);
        check("store_load_dir", rd[0], 32'hDEADBEEF);

        // Simultaneous requests from reset: port 0 load, port 1 store, same word
        do_reset();
        present(0, 1'b0, 4'd3, 32'h0);
        present(1, 1'b1, 4'd3, 32'h1234);
        serve(0, 2'b01);
        check("sim_first_load", rd[0], 32'h0);
        serve(1, 2'b10);
        present(0, 1'b0, 4'd3, 32'h0);
        serve(0, 2'b01);
        check("sim_after_store", rd[0], 32'h1234);

        // Continuous contention: grants alternate starting from the favoured port
        present(0, 1'b0, 4'd5, 32'h0);
        present(1, 1'b0, 4'd3, 32'h0);
        first = fav;
        for (int i = 0; i < 4; i++) begin
            check("contention_order", 32'(fav), 32'((first + i) % 2));
            serve(fav, (i == 3) ? 2'b11 : 2'b00);
        end

        // Reset during a store ACCESS: the write still lands
        present(0, 1'b1, 4'd9, 32'hCAFE0009);
        @(posedge clk); #1;
        check("rst_store_gnt", 32'(gnt), 32'd1);
        req = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[9] = 32'hCAFE0009;
        fav = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        check_all_zero("rst_store");

        // Reset during a port 1 load ACCESS: load dropped, no done
        present(1, 1'b0, 4'd7, 32'h0);
        @(posedge clk); #1;
        check("rst_load_gnt", 32'(gnt), 32'd2);
        req = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("rst_load");
        @(posedge clk); #1;
        check("rst_load_no_done", 32'(done), 32'd0);
        present(0, 1'b0, 4'd9, 32'h0);
        present(1, 1'b0, 4'd9, 32'h0);
        serve(0, 2'b01);
        serve(1, 2'b10);
        check("rst_store_landed", rd[1], 32'hCAFE0009);

        // Request held across done: three back-to-back port 0 loads
        lc = load_cycles;
        present(0, 1'b0, 4'd2, 32'h0);
        serve(0, 2'b00);
        serve(0, 2'b00);
        serve(0, 2'b01);
        check("held_load_cycles", 32'(load_cycles - lc), 32'd3);

        // Randomized single and contending transactions over a small address window
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                if (r[p]) present(p, 1'($urandom), 4'($urandom_range(0, 3)), $urandom);
            end
            if (r == 3) begin
                first = fav;
                serve(first, 2'(1 << first));
                serve(1 - first, 2'(1 << (1 - first)));
            end else begin
                serve(r - 1, 2'(r));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences and shares the 16-entry x 32-bit data memory file between two requesters: port 0 is the CPU load/store stage and port 1 is the debug/loader.
- Accepts one request at a time using round-robin arbitration.
- Drives the memory file's addr / write_data / ldr_str_en / load_en / store_en for exactly one cycle per transaction, then returns read data with a done pulse.
- Sits between the pipeline memory stage and the memory file.

Parameters:
ADDR_W, 4, memory address width (16 words)
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
req0  input  1  port 0 request
we0  input  1  port 0 1=store, 0=load
addr0  input  ADDR_W  port 0 word address
wdata0  input  DATA_W  port 0 store data
gnt0  output  1  port 0 request accepted (1-cycle pulse)
done0  output  1  port 0 transaction complete (1-cycle pulse)
rdata0  output  DATA_W  port 0 load result
req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as port 0, for port 1
mem_addr  output  ADDR_W  to memory file addr
mem_wdata  output  DATA_W  to memory file write_data
mem_ldr_str_en  output  1  to memory file ldr_str_en
mem_load_en  output  1  to memory file load_en
mem_store_en  output  1  to memory file store_en
mem_rdata  input  DATA_W  from memory file read_data
busy  output  1  transaction in progress (state != IDLE)
owner  output  1  port of the current/last granted transaction

Behaviour:
- Reset: clk and rst as named above. Synchronous active-high reset puts all outputs to 0 and the FSM to IDLE. The round-robin pointer is reset to favour port 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles; peak throughput is 1 transaction per 3 cycles.
- IDLE:
  - Samples req0/req1 each cycle.
  - If only one is high, that port wins. If both are high, the favoured port wins.
  - On the edge: latch the winner's we/addr/wdata, set owner, go to ACCESS, assert gntX for the ACCESS cycle.
  - If neither request is high, stay in IDLE. No mem_* enable is ever high in IDLE.
- ACCESS (1 cycle):
  - mem_ldr_str_en=1.
  - mem_store_en = latched we; mem_load_en = ~latched we.
  - mem_addr and mem_wdata come from the latched values, which are registered and stable for the whole cycle.
  - On the edge, for a load: capture mem_rdata into rdataX of the owner. For a store: rdataX is unchanged.
  - Go to RESP.
- RESP (1 cycle):
  - doneX=1 for the owner; all mem enables 0.
  - Round-robin pointer updates to favour the non-owner.
  - Go to IDLE.
- Request rules:
  - The requester's inputs are only sampled at acceptance. After gnt, the requester may change addr/wdata or drop req.
  - A req still high in the IDLE cycle after done is treated as a new request.
  - A requester not granted must hold req, we, addr and wdata stable until its gnt.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. No port waits more than one other transaction.
- Outputs:
  - mem_addr and mem_wdata hold their last value outside ACCESS.
  - rdataX holds its last load result until the next load completes on that port.
- Ordering: a store followed by a load to the same address (either port) returns the stored value, since the store completes before the load's ACCESS.
- Reset mid-transaction:
  - Next cycle is IDLE with all enables 0, no gnt/done pulse, pointer favouring port 0.
  - A store whose ACCESS cycle coincided with the reset cycle still took effect in memory.
  - A pending load is dropped and rdataX is reset to 0.
- No combinational paths from req inputs to any output. All outputs are registered or decoded from state only.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req0=req1=0 -> all outputs 0, busy=0, no mem_*_en asserted for 10 cycles.
- Single store/load on port 0: store 32'hDEADBEEF to addr 5, then load addr 5 -> gnt0 at T+1, mem_store_en=1 at T+1 only, done0 at T+2; load yields rdata0=32'hDEADBEEF with done0; rdata1 stays 0.
- Simultaneous requests from reset: req0 loads addr 3, req1 stores 32'h1234 to addr 3, both held -> port 0 granted first, rdata0=0 (initial memory); port 1 granted next; a following port 0 load of addr 3 returns 32'h1234.
- Continuous contention: both ports request loads for 12 cycles -> grant order 0,1,0,1; gnt pulses exactly 3 cycles apart; never gnt0 and gnt1 together.
- Reset mid-access: port 1 load of addr 7 accepted, rst=1 during its ACCESS cycle -> no done1, rdata1=0, FSM in IDLE, next simultaneous request grants port 0.
- Request held after done: req0 held high for 9 cycles, load addr 2 -> three back-to-back port 0 transactions, done0 every 3 cycles, mem_load_en high exactly 3 cycles total.
